vga_native_arbiter: RTL
=======================

VGA_NATIVE_ARBITER -- requirements
Module: vga_native_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, native word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, native data width (matches axil_data_t).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic on posedge.
REQ-004 SHALL have port arst_n_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have ports p0_req_i/p1_req_i, input, 1 bit: access request. p0 is the AXI-Lite slave FSM side; p1 is the display fetch side.
REQ-006 SHALL have ports p0_we_i/p1_we_i, input, 1 bit: 1 selects write, 0 selects read.
REQ-007 SHALL have ports p0_addr_i/p1_addr_i, input, ADDR_WIDTH bits: word address.
REQ-008 SHALL have ports p0_wdata_i/p1_wdata_i, input, DATA_WIDTH bits: write data.
REQ-009 SHALL have ports p0_gnt_o/p1_gnt_o, output, 1 bit: request accepted this cycle.
REQ-010 SHALL have ports p0_rvalid_o/p1_rvalid_o, output, 1 bit: read data valid.
REQ-011 SHALL have ports p0_rdata_o/p1_rdata_o, output, DATA_WIDTH bits: read data.
REQ-012 SHALL have ports mem_en_o, mem_we_o, mem_addr_o and mem_wdata_o, outputs, 1/1/ADDR_WIDTH/DATA_WIDTH bits: the single-port memory command.
REQ-013 SHALL have port mem_rdata_i, input, DATA_WIDTH bits: memory read data, valid one cycle after a read command.

Function
REQ-014 SHALL grant at most one port per cycle; pN_gnt_o is combinational from the pN_req_i inputs and the registered last-grant pointer.
REQ-015 SHALL drive mem_en_o = p0_gnt_o | p1_gnt_o, and mux mem_we_o, mem_addr_o and mem_wdata_o from the granted port in the same cycle; these outputs SHALL be 0 when there is no grant.
REQ-016 SHALL grant a sole requester in the same cycle as its request.
REQ-017 Requester SHALL hold req, we, addr and wdata stable until gnt is seen; the arbiter SHALL tolerate req dropping before gnt with no side effect.
REQ-018 SHALL assert pN_rvalid_o exactly one cycle after a read grant to port N, for one cycle, with pN_rdata_o = mem_rdata_i in that cycle.
REQ-019 pN_rdata_o SHALL be don't-care when pN_rvalid_o is 0, and SHALL NOT be routed to the other port.
REQ-020 Write grants SHALL never produce rvalid.
REQ-021 Back-to-back grants SHALL be sustained: one access per cycle, full throughput with both ports requesting.
REQ-022 Last-grant pointer SHALL update on every grant to the index of the granted port and SHALL hold when idle.
REQ-023 A read grant followed next cycle by a write grant to the same address SHALL return the old data (memory read-first ordering is passed through unchanged).

Reset
REQ-024 While arst_n_i = 0 at posedge: every pN_gnt_o = 0, every pN_rvalid_o = 0, mem_en_o = 0, mem_we_o = 0, and the pointer = 1, so that p0 wins the first contention.
REQ-025 Reset asserted one cycle after a read grant SHALL suppress the pending rvalid; no rvalid SHALL appear after reset release.

Configuration
REQ-026 With VGA_NATIVE_ARB_RR_EN defined: round-robin; on contention, grant the port not granted last.
REQ-027 Without VGA_NATIVE_ARB_RR_EN: fixed priority; p1 always wins contention, the pointer is unused, and p0 may starve.

Verification
REQ-028 p0 read addr 0x04, memory holds 0xDEADBEEF -> p0_gnt_o = 1 in cycle 0; p0_rvalid_o = 1 with p0_rdata_o = 0xDEADBEEF in cycle 1; p1_rvalid_o = 0.
REQ-029 p0 write 0x10 <- 0x12345678, then p1 read 0x10 -> mem_we_o = 1 in cycle 0; p1_rdata_o = 0x12345678 in cycle 2.
REQ-030 RR_EN, both ports continuously reading from reset -> grants alternate p0, p1, p0, p1; 8 grants in 8 cycles, 4 per port.
REQ-031 No RR_EN, both ports requesting for 5 cycles -> p1_gnt_o = 1 in all 5 cycles; p0_gnt_o = 0 throughout.
REQ-032 Read grant at cycle N, arst_n_i = 0 at cycle N+1 -> no rvalid at any cycle; after release, first contention is granted to p0 (RR_EN).
REQ-033 Bind an SVA module -> checks p0_gnt_o & p1_gnt_o never asserted together, and rvalid is always exactly one cycle after a read grant.

Source files
------------

// File: rtl/vga_native_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_native_arbiter_if
// Brief    : Two requester ports plus single-port memory command/response
//            bundle for the VGA native-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_native_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  p0_req_i;
    logic                  p0_we_i;
    logic [ADDR_WIDTH-1:0] p0_addr_i;
    logic [DATA_WIDTH-1:0] p0_wdata_i;
    logic                  p0_gnt_o;
    logic                  p0_rvalid_o;
    logic [DATA_WIDTH-1:0] p0_rdata_o;

    logic                  p1_req_i;
    logic                  p1_we_i;
    logic [ADDR_WIDTH-1:0] p1_addr_i;
    logic [DATA_WIDTH-1:0] p1_wdata_i;
    logic                  p1_gnt_o;
    logic                  p1_rvalid_o;
    logic [DATA_WIDTH-1:0] p1_rdata_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    // Arbiter side
    modport slave (
        input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        input  p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    // Requesters and memory side
    modport master (
        output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
        input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
        output p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i,
        input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface
`default_nettype wire

// File: rtl/vga_native_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vga_native_arbiter
// Brief    : Two-port arbiter in front of a single-port memory with one-cycle
//            read latency. Define VGA_NATIVE_ARB_RR_EN for round-robin;
//            otherwise p1 (display fetch) has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module vga_native_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  wire logic           clk_i,
    input  wire logic           arst_n_i,
    vga_native_arbiter_if.slave bus
);

    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  r_rd_pend0;
    logic                  r_rd_pend1;
    logic                  w_rvalid0;
    logic                  w_rvalid1;

`ifdef VGA_NATIVE_ARB_RR_EN
    // Pointer holds the index of the last granted port; 1 lets p0 win first.
    localparam logic c_ptr_rst = 1'b1;
    logic r_last;

    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            r_last <= c_ptr_rst;
        end else if (w_gnt0 || w_gnt1) begin
            r_last <= w_gnt1;
        end
    end
`endif

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (arst_n_i) begin
            if (bus.p0_req_i && bus.p1_req_i) begin
`ifdef VGA_NATIVE_ARB_RR_EN
                w_gnt0 = r_last;
                w_gnt1 = ~r_last;
`else
                w_gnt1 = 1'b1;
`endif
            end else begin
                w_gnt0 = bus.p0_req_i;
                w_gnt1 = bus.p1_req_i;
            end
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_gnt0) begin
            w_mem_we    = bus.p0_we_i;
            w_mem_addr  = bus.p0_addr_i;
            w_mem_wdata = bus.p0_wdata_i;
        end else if (w_gnt1) begin
            w_mem_we    = bus.p1_we_i;
            w_mem_addr  = bus.p1_addr_i;
            w_mem_wdata = bus.p1_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arst_n_i) begin
            r_rd_pend0 <= 1'b0;
            r_rd_pend1 <= 1'b0;
        end else begin
            r_rd_pend0 <= w_gnt0 & ~bus.p0_we_i;
            r_rd_pend1 <= w_gnt1 & ~bus.p1_we_i;
        end
    end

    // Gating with reset kills a response whose grant preceded a reset cycle.
    assign w_rvalid0 = r_rd_pend0 & arst_n_i;
    assign w_rvalid1 = r_rd_pend1 & arst_n_i;

    assign bus.p0_gnt_o    = w_gnt0;
    assign bus.p1_gnt_o    = w_gnt1;
    assign bus.p0_rvalid_o = w_rvalid0;
    assign bus.p1_rvalid_o = w_rvalid1;
    assign bus.p0_rdata_o  = w_rvalid0 ? bus.mem_rdata_i : '0;
    assign bus.p1_rdata_o  = w_rvalid1 ? bus.mem_rdata_i : '0;

    assign bus.mem_en_o    = w_gnt0 | w_gnt1;
    assign bus.mem_we_o    = w_mem_we;
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = w_mem_wdata;

endmodule
`default_nettype wire
